alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share a single ALU. Each port owns a one-deep
// response register. At most one operation is accepted per cycle. A port may
// be accepted while its response register is being drained in the same
// cycle, so a port can complete one operation per cycle.
//
// Build option: define ALU_ARBITER_RR_EN to select round-robin arbitration
// between the two ports. Without it, port 0 always wins contention and no
// pointer register exists.
//
// ALU opcode encoding:
//   0000 add   0001 sub   0010 and   0011 or    0100 xor
//   0101 sll   0110 srl   0111 sra   1000 slt (signed)   1001 sltu
//   any other opcode produces 0.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,
    input  logic [3:0]  req0_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,
    input  logic [3:0]  req1_op,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic [31:0] ops_done
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    // Per-port views of the flat port list, so the per-port logic is written once
    logic        req_valid  [2];
    logic [31:0] req_src1   [2];
    logic [31:0] req_src2   [2];
    logic [3:0]  req_op     [2];
    logic        rsp_ready  [2];
    logic        eligible   [2];
    logic        grant      [2];
    logic        handshake  [2];

    logic        rsp_valid_reg  [2];
    logic [31:0] rsp_result_reg [2];
    logic [31:0] ops_done_reg;

    logic        prefer0;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [1:0]  handshake_count;

    assign req_valid[0] = req0_valid;
    assign req_valid[1] = req1_valid;
    assign req_src1[0]  = req0_src1;
    assign req_src1[1]  = req1_src1;
    assign req_src2[0]  = req0_src2;
    assign req_src2[1]  = req1_src2;
    assign req_op[0]    = req0_op;
    assign req_op[1]    = req1_op;
    assign rsp_ready[0] = rsp0_ready;
    assign rsp_ready[1] = rsp1_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // A port can take a new op when its response slot is empty or being drained now
            assign eligible[gi]  = req_valid[gi] && (!rsp_valid_reg[gi] || rsp_ready[gi]);
            assign handshake[gi] = rsp_valid_reg[gi] && rsp_ready[gi];

            // Response register: load on grant, clear on drain, otherwise hold
            always_ff @(posedge clk) begin
                if (rst) begin
                    rsp_valid_reg[gi]  <= 1'b0;
                    rsp_result_reg[gi] <= 32'd0;
                end else if (grant[gi]) begin
                    rsp_valid_reg[gi]  <= 1'b1;
                    rsp_result_reg[gi] <= alu_result;
                end else if (handshake[gi]) begin
                    rsp_valid_reg[gi]  <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef ALU_ARBITER_RR_EN
    // 1 means port 1 was granted most recently; reset value lets port 0 win first
    logic last_grant_reg;

    assign prefer0 = last_grant_reg;

    // Round-robin pointer records the port that received the latest grant
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else if (grant[0]) begin
            last_grant_reg <= 1'b0;
        end else if (grant[1]) begin
            last_grant_reg <= 1'b1;
        end
    end
`else
    // Fixed priority: port 0 always wins contention
    assign prefer0 = 1'b1;
`endif

    // Nothing is accepted while reset is held
    assign grant[0] = !rst && eligible[0] && (!eligible[1] || prefer0);
    assign grant[1] = !rst && eligible[1] && !grant[0];

    // Operand mux into the shared ALU; idle cycles present zeros
    always_comb begin
        alu_src1 = 32'd0;
        alu_src2 = 32'd0;
        alu_op   = 4'd0;
        if (grant[0]) begin
            alu_src1 = req_src1[0];
            alu_src2 = req_src2[0];
            alu_op   = req_op[0];
        end else if (grant[1]) begin
            alu_src1 = req_src1[1];
            alu_src2 = req_src2[1];
            alu_op   = req_op[1];
        end
    end

    // The single shared ALU
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            OP_ADD:  alu_result = alu_src1 + alu_src2;
            OP_SUB:  alu_result = alu_src1 - alu_src2;
            OP_AND:  alu_result = alu_src1 & alu_src2;
            OP_OR:   alu_result = alu_src1 | alu_src2;
            OP_XOR:  alu_result = alu_src1 ^ alu_src2;
            OP_SLL:  alu_result = alu_src1 << alu_src2[4:0];
            OP_SRL:  alu_result = alu_src1 >> alu_src2[4:0];
            OP_SRA:  alu_result = $signed(alu_src1) >>> alu_src2[4:0];
            OP_SLT:  alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
            OP_SLTU: alu_result = {31'd0, alu_src1 < alu_src2};
            default: alu_result = 32'd0;
        endcase
    end

    assign handshake_count = {1'b0, handshake[0]} + {1'b0, handshake[1]};

    // Completed-response counter; both ports may drain in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done_reg <= 32'd0;
        end else begin
            ops_done_reg <= ops_done_reg + {30'd0, handshake_count};
        end
    end

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign rsp0_valid  = rsp_valid_reg[0];
    assign rsp1_valid  = rsp_valid_reg[1];
    assign rsp0_result = rsp_result_reg[0];
    assign rsp1_result = rsp_result_reg[1];
    assign ops_done    = ops_done_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level model of the arbiter kept here.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] ops_done;

    int checks = 0;
    int errors = 0;

    // Model state: what each response slot should hold, who won last, counter
    bit          m_valid  [2];
    logic [31:0] m_result [2];
    int          m_last;
    logic [31:0] m_ops;

    // Stimulus applied this cycle and the grants the model expects from it
    bit          d_rst;
    bit          d_valid [2];
    logic [31:0] d_a     [2];
    logic [31:0] d_b     [2];
    logic [3:0]  d_op    [2];
    bit          d_rready[2];
    bit          exp_gnt [2];

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Reference ALU written from the opcode table
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return $signed(a) >>> sh;
            4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Apply one cycle of stimulus after the falling edge and predict the grants
    task automatic drive(input bit r,
                         input bit v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0, input bit rr0,
                         input bit v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1, input bit rr1);
        bit e0, e1;
        @(negedge clk);
        rst = r;
        req0_valid = v0; req0_src1 = a0; req0_src2 = b0; req0_op = o0; rsp0_ready = rr0;
        req1_valid = v1; req1_src1 = a1; req1_src2 = b1; req1_op = o1; rsp1_ready = rr1;
        d_rst = r;
        d_valid[0] = v0; d_a[0] = a0; d_b[0] = b0; d_op[0] = o0; d_rready[0] = rr0;
        d_valid[1] = v1; d_a[1] = a1; d_b[1] = b1; d_op[1] = o1; d_rready[1] = rr1;
        e0 = v0 && (!m_valid[0] || rr0);
        e1 = v1 && (!m_valid[1] || rr1);
        exp_gnt[0] = 1'b0;
        exp_gnt[1] = 1'b0;
        if (!r) begin
            if (e0 && e1) begin
`ifdef ALU_ARBITER_RR_EN
                exp_gnt[1 - m_last] = 1'b1;
`else
                exp_gnt[0] = 1'b1;
`endif
            end else if (e0) begin
                exp_gnt[0] = 1'b1;
            end else if (e1) begin
                exp_gnt[1] = 1'b1;
            end
        end
        #1;
    endtask

    // Advance through the rising edge and move the model to its next state
    task automatic tick();
        int hs;
        @(posedge clk);
        if (d_rst) begin
            m_valid[0] = 0; m_valid[1] = 0;
            m_result[0] = 0; m_result[1] = 0;
            m_ops = 0;
            m_last = 1;
        end else begin
            hs = 0;
            for (int p = 0; p < 2; p++) if (m_valid[p] && d_rready[p]) hs++;
            m_ops = m_ops + 32'(hs);
            for (int p = 0; p < 2; p++) begin
                if (exp_gnt[p]) begin
                    m_valid[p]  = 1;
                    m_result[p] = alu_ref(d_op[p], d_a[p], d_b[p]);
                    m_last      = p;
                    $display("txn t=%0t port%0d op=%h a=%h b=%h result=%h", $time, p, d_op[p], d_a[p], d_b[p], m_result[p]);
                end else if (m_valid[p] && d_rready[p]) begin
                    m_valid[p] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_drain();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset();
        drive(1, 1, 32'd1, 32'd2, 4'd0, 1, 1, 32'd3, 32'd4, 4'd0, 1);
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b want 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b want 0", req1_ready); end
        tick();
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b want 00", rsp1_valid, rsp0_valid); end
        checks++; if (rsp0_result !== 32'd0 || rsp1_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h/%h want 0/0", rsp0_result, rsp1_result); end
        checks++; if (ops_done !== 32'd0) begin errors++; $display("FAIL reset_ops got %h want 0", ops_done); end
    endtask

    task automatic test_single();
        drive(0, 1, 32'd5, 32'd7, 4'b0000, 1, 0, 0, 0, 0, 1);
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b want 01", req1_ready, req0_ready); end
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd12) begin errors++; $display("FAIL single_result got v=%b %0d want v=1 12", rsp0_valid, rsp0_result); end
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tick();
        checks++; if (ops_done !== 32'd1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_ops got ops=%0d v=%b want 1 0", ops_done, rsp0_valid); end
    endtask

    task automatic test_round_robin();
        int pattern [4];
`ifdef ALU_ARBITER_RR_EN
        pattern = '{0, 1, 0, 1};
`else
        pattern = '{0, 0, 0, 0};
`endif
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, 32'd10, 32'd3, 4'b0001, 1, 1, 32'hFFFF_FFFF, 32'd5, 4'b1000, 1);
            checks++;
            if (req0_ready !== (pattern[c] == 0) || req1_ready !== (pattern[c] == 1)) begin
                errors++; $display("FAIL rr_grant cycle %0d got %b%b want port %0d", c, req1_ready, req0_ready, pattern[c]);
            end
            tick();
            checks++;
            if (pattern[c] == 0 && (rsp0_valid !== 1'b1 || rsp0_result !== 32'd7)) begin
                errors++; $display("FAIL rr_result0 cycle %0d got v=%b %0d want 7", c, rsp0_valid, rsp0_result);
            end else if (pattern[c] == 1 && (rsp1_valid !== 1'b1 || rsp1_result !== 32'd1)) begin
                errors++; $display("FAIL rr_result1 cycle %0d got v=%b %0d want 1", c, rsp1_valid, rsp1_result);
            end
        end
        checks++; if (ops_done !== m_ops) begin errors++; $display("FAIL rr_ops got %0d want %0d", ops_done, m_ops); end
    endtask

    task automatic test_backpressure();
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tick();
        drive(0, 1, 32'hFFFF_00FF, 32'hFFFF_FF00, 4'b0010, 0, 0, 0, 0, 0, 1);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_first_grant got %b want 1", req0_ready); end
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'hFFFF_0000) begin errors++; $display("FAIL bp_first_result got v=%b %h want FFFF0000", rsp0_valid, rsp0_result); end
        for (int c = 0; c < 2; c++) begin
            drive(0, 1, 32'hFFFF_00FF, 32'hFFFF_FF00, 4'b0010, 0, 1, 32'd1, 32'd2, 4'b0000, 1);
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL bp_stall cycle %0d got %b%b want 10", c, req1_ready, req0_ready); end
            tick();
            checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'hFFFF_0000) begin errors++; $display("FAIL bp_hold cycle %0d got v=%b %h want FFFF0000", c, rsp0_valid, rsp0_result); end
            checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd3) begin errors++; $display("FAIL bp_port1 cycle %0d got v=%b %0d want 3", c, rsp1_valid, rsp1_result); end
        end
        drive(0, 1, 32'hFFFF_00FF, 32'hFFFF_FF00, 4'b0010, 1, 0, 0, 0, 0, 1);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_grant got %b want 1", req0_ready); end
        tick();
        checks++; if (rsp0_valid !== 1'b1 || ops_done !== 32'd3) begin errors++; $display("FAIL bp_back_to_back got v=%b ops=%0d want 1 3", rsp0_valid, ops_done); end
    endtask

    task automatic test_undefined_op();
        idle_drain();
        drive(0, 1, $urandom, $urandom, 4'hF, 1, 0, 0, 0, 0, 1);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL undef_grant0 got %b want 1", req0_ready); end
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd0) begin errors++; $display("FAIL undef_result0 got v=%b %h want 0", rsp0_valid, rsp0_result); end
        drive(0, 0, 0, 0, 0, 1, 1, $urandom, $urandom, 4'hC, 1);
        tick();
        checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd0) begin errors++; $display("FAIL undef_result1 got v=%b %h want 0", rsp1_valid, rsp1_result); end
        idle_drain();
        checks++; if (ops_done !== m_ops) begin errors++; $display("FAIL undef_ops got %0d want %0d", ops_done, m_ops); end
    endtask

    task automatic test_reset_mid();
        idle_drain();
        drive(0, 0, 0, 0, 0, 1, 1, 32'd9, 32'd1, 4'd0, 0);
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rmid_grant got %b want 1", req1_ready); end
        tick();
        drive(1, 1, 32'd1, 32'd1, 4'd0, 1, 1, 32'd1, 32'd1, 4'd0, 1);
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b%b want 00", req1_ready, req0_ready); end
        tick();
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || ops_done !== 32'd0) begin errors++; $display("FAIL rmid_clear got v=%b%b ops=%0d want 00 0", rsp1_valid, rsp0_valid, ops_done); end
        drive(0, 1, 32'd1, 32'd1, 4'd0, 1, 1, 32'd1, 32'd1, 4'd0, 1);
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_first_contention got %b%b want 01", req1_ready, req0_ready); end
        tick();
    endtask

    task automatic test_wrap();
        idle_drain();
        drive(0, 1, 32'd2, 32'd2, 4'd0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 32'd3, 32'd3, 4'd0, 0);
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b1) begin errors++; $display("FAIL wrap_setup got v=%b%b want 11", rsp1_valid, rsp0_valid); end
        force dut.ops_done_reg = 32'hFFFF_FFFF;
        #1;
        release dut.ops_done_reg;
        m_ops = 32'hFFFF_FFFF;
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tick();
        checks++; if (ops_done !== 32'd1) begin errors++; $display("FAIL wrap_ops got %h want 00000001", ops_done); end
    endtask

    task automatic test_random();
        logic [31:0] a [2];
        logic [31:0] b [2];
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < 2; p++) begin
                a[p] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                b[p] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            end
            drive($urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0, a[0], b[0], 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) != 0, a[1], b[1], 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
            checks++; if (req0_ready !== exp_gnt[0]) begin errors++; $display("FAIL rand_ready0 cycle %0d got %b want %b", c, req0_ready, exp_gnt[0]); end
            checks++; if (req1_ready !== exp_gnt[1]) begin errors++; $display("FAIL rand_ready1 cycle %0d got %b want %b", c, req1_ready, exp_gnt[1]); end
            tick();
            checks++; if (rsp0_valid !== m_valid[0] || (m_valid[0] && rsp0_result !== m_result[0])) begin errors++; $display("FAIL rand_rsp0 cycle %0d got v=%b %h want v=%b %h", c, rsp0_valid, rsp0_result, m_valid[0], m_result[0]); end
            checks++; if (rsp1_valid !== m_valid[1] || (m_valid[1] && rsp1_result !== m_result[1])) begin errors++; $display("FAIL rand_rsp1 cycle %0d got v=%b %h want v=%b %h", c, rsp1_valid, rsp1_result, m_valid[1], m_result[1]); end
            checks++; if (ops_done !== m_ops) begin errors++; $display("FAIL rand_ops cycle %0d got %0d want %0d", c, ops_done, m_ops); end
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_src1 = 0; req0_src2 = 0; req0_op = 0; rsp0_ready = 0;
        req1_valid = 0; req1_src1 = 0; req1_src2 = 0; req1_op = 0; rsp1_ready = 0;
        m_valid[0] = 0; m_valid[1] = 0;
        m_result[0] = 0; m_result[1] = 0;
        m_last = 1;
        m_ops = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_undefined_op();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
